// File: rtl/tmvp_operand_streamer.sv
// rtl/tmvp_operand_streamer.sv - ping-pong row/vector buffer feeding the TMVP multiplier stream
module tmvp_operand_streamer #(
    parameter int N          = 16,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = $clog2(2*N)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic                  wr_sel,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  commit,
    input  logic                  stall,
    output logic                  wr_full,
    output logic [DATA_WIDTH-1:0] m_axis_tdata_row,
    output logic [DATA_WIDTH-1:0] m_axis_tdata_vec,
    output logic                  m_axis_tvalid,
    output logic                  busy,
    output logic                  problem_done
);

    // Vector index width; the vector buffer has N entries.
    localparam int VW = (N > 1) ? $clog2(N) : 1;
    localparam logic [ADDR_WIDTH-1:0] ROW_LAST = ADDR_WIDTH'(2*N-2);
    localparam logic [ADDR_WIDTH-1:0] VEC_LAST = ADDR_WIDTH'(N-1);

    typedef enum logic {IDLE, STREAM} state_t;

    // Two banks: the host fills bank wbank while bank rbank streams.
    logic [DATA_WIDTH-1:0] row_mem [2][2*N-1];
    logic [DATA_WIDTH-1:0] vec_mem [2][N];

    state_t                state;
    logic [ADDR_WIDTH-1:0] cnt;
    logic [1:0]            pending;
    logic [1:0]            pending_nxt;
    logic                  wbank;
    logic                  rbank;
    logic                  commit_ok;
    logic                  release_bank;

    assign wr_full      = (pending == 2'd2);
    assign busy         = (state == STREAM) || (pending != 2'd0);
    assign commit_ok    = commit && !wr_full;
    // The last beat of a problem hands its bank back to the writer.
    assign release_bank = (state == STREAM) && !stall && (cnt == ROW_LAST);

    // Pending-bank count; a commit and a release on the same edge cancel out.
    always_comb begin
        pending_nxt = pending;
        if (commit_ok && !release_bank) begin
            pending_nxt = pending + 2'd1;
        end else if (release_bank && !commit_ok) begin
            pending_nxt = pending - 2'd1;
        end
    end

    // Host writes into the current write bank; buffer contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en && !wr_full) begin
            if (!wr_sel && (wr_addr <= ROW_LAST)) begin
                row_mem[wbank][wr_addr] <= wr_data;
            end
            if (wr_sel && (wr_addr <= VEC_LAST)) begin
                vec_mem[wbank][wr_addr[VW-1:0]] <= wr_data;
            end
        end
    end

    // Bank bookkeeping and the IDLE/STREAM beat sequencer with registered stream outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            cnt              <= '0;
            pending          <= 2'd0;
            wbank            <= 1'b0;
            rbank            <= 1'b0;
            m_axis_tvalid    <= 1'b0;
            m_axis_tdata_row <= '0;
            m_axis_tdata_vec <= '0;
            problem_done     <= 1'b0;
        end else begin
            pending          <= pending_nxt;
            if (commit_ok) begin
                wbank <= ~wbank;
            end
            m_axis_tvalid    <= 1'b0;
            m_axis_tdata_row <= '0;
            m_axis_tdata_vec <= '0;
            problem_done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (pending != 2'd0) begin
                        state <= STREAM;
                        cnt   <= '0;
                    end
                end
                STREAM: begin
                    if (!stall) begin
                        m_axis_tvalid    <= 1'b1;
                        m_axis_tdata_row <= row_mem[rbank][cnt];
                        // Vector beats past N-1 are zero padding for the Toeplitz tail.
                        m_axis_tdata_vec <= (cnt <= VEC_LAST) ? vec_mem[rbank][cnt[VW-1:0]] : '0;
                        if (cnt == ROW_LAST) begin
                            problem_done <= 1'b1;
                            rbank        <= ~rbank;
                            cnt          <= '0;
                            if (pending_nxt == 2'd0) begin
                                state <= IDLE;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tmvp_operand_streamer.sv
// tb/tb_tmvp_operand_streamer.sv - directed self-checking bench for tmvp_operand_streamer
module tb_tmvp_operand_streamer;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_en;
    logic          wr_sel;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          commit;
    logic          stall;
    logic          wr_full;
    logic [DW-1:0] m_axis_tdata_row;
    logic [DW-1:0] m_axis_tdata_vec;
    logic          m_axis_tvalid;
    logic          busy;
    logic          problem_done;

    int vectors     = 0;
    int miscompares = 0;

    logic [DW-1:0] cr[$];
    logic [DW-1:0] cv[$];
    logic          cd[$];
    int            cc[$];

    tmvp_operand_streamer #(.N(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk              (clk),
        .reset            (reset),
        .wr_en            (wr_en),
        .wr_sel           (wr_sel),
        .wr_addr          (wr_addr),
        .wr_data          (wr_data),
        .commit           (commit),
        .stall            (stall),
        .wr_full          (wr_full),
        .m_axis_tdata_row (m_axis_tdata_row),
        .m_axis_tdata_vec (m_axis_tdata_vec),
        .m_axis_tvalid    (m_axis_tvalid),
        .busy             (busy),
        .problem_done     (problem_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic sel, input int addr, input int data);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_addr = AW'(addr);
        wr_data = DW'(data);
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic fill(input int rb, input int vb);
        for (int i = 0; i < 2*N-1; i++) wr(1'b0, i, rb + i);
        for (int i = 0; i < N; i++) wr(1'b1, i, vb + i);
    endtask

    task automatic pulse_commit();
        commit = 1'b1;
        tick();
        commit = 1'b0;
    endtask

    task automatic capture(input int ncyc);
        cr.delete(); cv.delete(); cd.delete(); cc.delete();
        for (int i = 0; i < ncyc; i++) begin
            tick();
            if (m_axis_tvalid) begin
                cr.push_back(m_axis_tdata_row);
                cv.push_back(m_axis_tdata_vec);
                cd.push_back(problem_done);
                cc.push_back(i);
            end
        end
    endtask

    // Reference multiplier: y[k] = sum_j R[k+j]*V[j] over the captured beats starting at off.
    function automatic int ymodel(input int k, input int off);
        int s = 0;
        for (int j = 0; j < N; j++)
            s += int'($signed(cr[off+k+j])) * int'($signed(cv[off+j]));
        return s;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        vectors++; if (m_axis_tvalid !== 1'b0) begin miscompares++; $display("FAIL reset_tvalid got %0b want 0", m_axis_tvalid); end
        vectors++; if (m_axis_tdata_row !== 8'h00) begin miscompares++; $display("FAIL reset_row got %h want 00", m_axis_tdata_row); end
        vectors++; if (m_axis_tdata_vec !== 8'h00) begin miscompares++; $display("FAIL reset_vec got %h want 00", m_axis_tdata_vec); end
        vectors++; if (problem_done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %0b want 0", problem_done); end
        vectors++; if (wr_full !== 1'b0) begin miscompares++; $display("FAIL reset_wr_full got %0b want 0", wr_full); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %0b want 0", busy); end
        reset = 1'b0;
        tick();
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL idle_busy got %0b want 0", busy); end
    endtask

    task automatic test_single();
        fill(1, 1);
        pulse_commit();
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL single_busy got %0b want 1", busy); end
        capture(14);
        vectors++; if (cr.size() != 7) begin miscompares++; $display("FAIL single_count got %0d want 7", cr.size()); end
        for (int k = 0; k < 7 && k < cr.size(); k++) begin
            vectors++; if (cc[k] != k + 1) begin miscompares++; $display("FAIL single_cycle[%0d] got %0d want %0d", k, cc[k], k + 1); end
            vectors++; if (cr[k] !== 8'(k + 1)) begin miscompares++; $display("FAIL single_row[%0d] got %0d want %0d", k, cr[k], k + 1); end
            vectors++; if (cv[k] !== ((k < N) ? 8'(k + 1) : 8'd0)) begin miscompares++; $display("FAIL single_vec[%0d] got %0d", k, cv[k]); end
            vectors++; if (cd[k] !== (k == 6)) begin miscompares++; $display("FAIL single_done[%0d] got %0b", k, cd[k]); end
        end
        if (cr.size() == 7) begin
            for (int k = 0; k < N; k++) begin
                vectors++; if (ymodel(k, 0) != 30 + 10*k) begin miscompares++; $display("FAIL single_y[%0d] got %0d want %0d", k, ymodel(k, 0), 30 + 10*k); end
            end
        end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL single_busy_end got %0b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        stall = 1'b1;
        fill(1, 1);
        pulse_commit();
        fill(2, 1);
        pulse_commit();
        vectors++; if (wr_full !== 1'b1) begin miscompares++; $display("FAIL b2b_wr_full got %0b want 1", wr_full); end
        wr(1'b1, 0, 9);
        pulse_commit();
        vectors++; if (wr_full !== 1'b1) begin miscompares++; $display("FAIL full_wr_full got %0b want 1", wr_full); end
        stall = 1'b0;
        capture(24);
        vectors++; if (cr.size() != 14) begin miscompares++; $display("FAIL b2b_count got %0d want 14", cr.size()); end
        for (int k = 0; k < 14 && k < cr.size(); k++) begin
            int p = k % 7;
            vectors++; if (cc[k] != k) begin miscompares++; $display("FAIL b2b_cycle[%0d] got %0d want %0d", k, cc[k], k); end
            vectors++; if (cr[k] !== 8'((k < 7) ? p + 1 : p + 2)) begin miscompares++; $display("FAIL b2b_row[%0d] got %0d", k, cr[k]); end
            vectors++; if (cv[k] !== ((p < N) ? 8'(p + 1) : 8'd0)) begin miscompares++; $display("FAIL b2b_vec[%0d] got %0d", k, cv[k]); end
            vectors++; if (cd[k] !== (p == 6)) begin miscompares++; $display("FAIL b2b_done[%0d] got %0b", k, cd[k]); end
        end
        if (cr.size() == 14) begin
            for (int k = 0; k < N; k++) begin
                vectors++; if (ymodel(k, 0) != 30 + 10*k) begin miscompares++; $display("FAIL b2b_ya[%0d] got %0d want %0d", k, ymodel(k, 0), 30 + 10*k); end
                vectors++; if (ymodel(k, 7) != 40 + 10*k) begin miscompares++; $display("FAIL b2b_yb[%0d] got %0d want %0d", k, ymodel(k, 7), 40 + 10*k); end
            end
        end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL b2b_busy_end got %0b want 0", busy); end
        vectors++; if (wr_full !== 1'b0) begin miscompares++; $display("FAIL b2b_wr_full_end got %0b want 0", wr_full); end
    endtask

    task automatic test_stall();
        fill(1, 1);
        pulse_commit();
        cr.delete(); cv.delete(); cd.delete(); cc.delete();
        for (int i = 0; i < 16; i++) begin
            stall = (i >= 4 && i <= 6);
            tick();
            if (m_axis_tvalid) begin
                cr.push_back(m_axis_tdata_row);
                cv.push_back(m_axis_tdata_vec);
                cd.push_back(problem_done);
                cc.push_back(i);
            end else begin
                vectors++;
                if (m_axis_tdata_row !== 8'h00 || m_axis_tdata_vec !== 8'h00) begin
                    miscompares++; $display("FAIL stall_idle_data cycle %0d got %h/%h want 00/00", i, m_axis_tdata_row, m_axis_tdata_vec);
                end
            end
        end
        stall = 1'b0;
        vectors++; if (cr.size() != 7) begin miscompares++; $display("FAIL stall_count got %0d want 7", cr.size()); end
        for (int k = 0; k < 7 && k < cr.size(); k++) begin
            vectors++; if (cc[k] != ((k < 3) ? k + 1 : k + 4)) begin miscompares++; $display("FAIL stall_cycle[%0d] got %0d want %0d", k, cc[k], (k < 3) ? k + 1 : k + 4); end
            vectors++; if (cr[k] !== 8'(k + 1)) begin miscompares++; $display("FAIL stall_row[%0d] got %0d want %0d", k, cr[k], k + 1); end
            vectors++; if (cv[k] !== ((k < N) ? 8'(k + 1) : 8'd0)) begin miscompares++; $display("FAIL stall_vec[%0d] got %0d", k, cv[k]); end
        end
    endtask

    task automatic test_addr_bounds();
        fill(1, 1);
        wr(1'b0, 7, 8'h55);
        wr(1'b1, 4, 8'h55);
        pulse_commit();
        capture(14);
        vectors++; if (cr.size() != 7) begin miscompares++; $display("FAIL bounds_count got %0d want 7", cr.size()); end
        for (int k = 0; k < 7 && k < cr.size(); k++) begin
            vectors++; if (cr[k] !== 8'(k + 1)) begin miscompares++; $display("FAIL bounds_row[%0d] got %0d want %0d", k, cr[k], k + 1); end
            vectors++; if (cv[k] !== ((k < N) ? 8'(k + 1) : 8'd0)) begin miscompares++; $display("FAIL bounds_vec[%0d] got %0d", k, cv[k]); end
        end
    endtask

    task automatic test_signed();
        fill(0, 0);
        wr(1'b0, 0, 8'h80);
        wr(1'b1, 0, 8'h7F);
        pulse_commit();
        capture(14);
        vectors++; if (cr.size() != 7) begin miscompares++; $display("FAIL signed_count got %0d want 7", cr.size()); end
        if (cr.size() == 7) begin
            vectors++; if (cr[0] !== 8'h80) begin miscompares++; $display("FAIL signed_row0 got %h want 80", cr[0]); end
            vectors++; if (cv[0] !== 8'h7F) begin miscompares++; $display("FAIL signed_vec0 got %h want 7f", cv[0]); end
            vectors++; if (cr[1] !== 8'h01) begin miscompares++; $display("FAIL signed_row1 got %h want 01", cr[1]); end
            vectors++; if (ymodel(0, 0) != -16242) begin miscompares++; $display("FAIL signed_y0 got %0d want -16242", ymodel(0, 0)); end
        end
    endtask

    task automatic test_reset_mid();
        fill(1, 1);
        pulse_commit();
        pulse_commit();
        vectors++; if (wr_full !== 1'b1) begin miscompares++; $display("FAIL mid_wr_full got %0b want 1", wr_full); end
        for (int i = 0; i < 5; i++) tick();
        vectors++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata_row !== 8'd5) begin miscompares++; $display("FAIL mid_beat4 got v=%0b row=%0d want v=1 row=5", m_axis_tvalid, m_axis_tdata_row); end
        #2;
        reset = 1'b1;
        #1;
        vectors++; if (m_axis_tvalid !== 1'b0) begin miscompares++; $display("FAIL mid_tvalid got %0b want 0", m_axis_tvalid); end
        vectors++; if (m_axis_tdata_row !== 8'h00) begin miscompares++; $display("FAIL mid_row got %h want 00", m_axis_tdata_row); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL mid_busy got %0b want 0", busy); end
        vectors++; if (wr_full !== 1'b0) begin miscompares++; $display("FAIL mid_wr_full_rst got %0b want 0", wr_full); end
        tick();
        reset = 1'b0;
        capture(10);
        vectors++; if (cr.size() != 0) begin miscompares++; $display("FAIL mid_quiet got %0d beats want 0", cr.size()); end
        fill(1, 1);
        pulse_commit();
        capture(14);
        vectors++; if (cr.size() != 7) begin miscompares++; $display("FAIL mid_restart_count got %0d want 7", cr.size()); end
        if (cr.size() == 7) begin
            vectors++; if (cc[0] != 1) begin miscompares++; $display("FAIL mid_restart_latency got %0d want 1", cc[0]); end
            vectors++; if (cr[0] !== 8'd1) begin miscompares++; $display("FAIL mid_restart_row0 got %0d want 1", cr[0]); end
            vectors++; if (cd[6] !== 1'b1) begin miscompares++; $display("FAIL mid_restart_done got %0b want 1", cd[6]); end
        end
    endtask

    initial begin
        reset   = 1'b1;
        wr_en   = 1'b0;
        wr_sel  = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        commit  = 1'b0;
        stall   = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_addr_bounds();
        test_signed();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
